div_seq_ctrl: RTL and testbench
===============================

# div_seq_ctrl

Multi-cycle sequencer for the CPU's 32-bit integer divide. It accepts a dividend/divisor pair under a start/busy/done handshake and runs one restoring shift-subtract step per clock, MSB first. It delivers quotient and remainder to the HI/LO write-back path. It replaces the single-cycle combinational divider on the ALU's DIV opcode path, so the divide no longer sets the critical path.

## Interface
- WIDTH, 32, operand/result width; only 32 is verified.
- clock  in  1  rising-edge system clock.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- is_signed  in  1  signed-divide request; ignored unless DIV_SIGNED_EN.
- dividend  in  WIDTH  D operand; captured on accepted start.
- divisor  in  WIDTH  V operand; captured on accepted start.
- abort  in  1  synchronous cancel (pipeline flush).
- busy  out  1  high from the cycle after accept until done.
- done  out  1  one-cycle pulse when results are valid.
- div_zero  out  1  set with done when V=0; held until next accept.
- quotient  out  WIDTH  Q (to LO); held until next accept.
- remainder  out  WIDTH  R (to HI); held until next accept.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE + start (abort=0): capture operands, clear div_zero, cnt=WIDTH-1.
  - V=0: go to DONE; Q=all-ones, R=dividend, div_zero=1.
  - Otherwise: go to RUN; partial remainder P=0, working quotient=|D|.
- RUN, each cycle:
  - Compute P'={P,Qw[MSB]}. If P'>=V: P=P'-V and shift 1 into the Qw LSB. Else P=P' and shift 0 into the Qw LSB.
  - Arithmetic is WIDTH+1 bits, so no overflow.
  - cnt decrements. At cnt=0 go to FIX if DIV_SIGNED_EN and is_signed, else go to DONE.
- FIX: negate Q if the operand signs differ; R takes the sign of the dividend.
- DONE: done=1 for exactly this cycle, then IDLE. quotient/remainder/div_zero hold.
- busy=1 in RUN and FIX.
- start while busy=1: ignored, no queuing.
- abort in RUN/FIX: go to IDLE next cycle. No done. Outputs keep the previous result.
- abort and start in the same cycle: abort wins, request dropped.
- Start accepted in DONE is legal: a back-to-back divide with no idle cycle.

## Timing
- Reset (async, clear_n=0): state=IDLE, busy=0, done=0, div_zero=0, quotient=0, remainder=0, internal registers 0.
- Deassertion is used synchronously downstream. The block needs no reset synchronizer inside.
- Accept at edge E0; RUN steps occupy edges E1..E32.
  - Unsigned: done and results valid in the cycle after E32. Latency 33 cycles, accept to done.
  - Signed with FIX: 34 cycles.
- Divide-by-zero: done in the cycle after E0, busy never asserts.
- Results update only on the edge entering DONE.
- Throughput: one divide per 33 (34) cycles with back-to-back starts.

## Configuration
- DIV_SIGNED_EN defined:
  - is_signed honoured. Operands are converted to magnitude at accept and the FIX state exists.
  - 0x80000000 / 0xFFFFFFFF yields Q=0x80000000, R=0 (wraps, no trap).
  - Signed divide-by-zero yields Q=all-ones, R=dividend.
- DIV_SIGNED_EN undefined:
  - is_signed is ignored, all divides are unsigned, and FIX logic is absent.
  - Latency is always 33 cycles.

## Structure
- Shared package div_pkg:
  - DIV_WIDTH=32.
  - Counter width constant $clog2(DIV_WIDTH).
  - State enum div_state_t {IDLE, RUN, FIX, DONE}.
- Sub-module div_step: purely combinational single restoring step.
  - Inputs P, Qw MSB, V. Outputs next P and quotient bit.
  - Instantiated once in div_seq_ctrl.
- The controller holds the FSM, counter, operand/result registers and sign logic.

## Test plan
- 100 / 7, unsigned: done exactly 33 cycles after accept; quotient=14, remainder=2, div_zero=0.
- 0xFFFFFFFF / 1, then back-to-back start in the DONE cycle with 0x0000000A / 0x00000003: Q=0xFFFFFFFF, R=0; then Q=3, R=1 after another 33 cycles.
- 5 / 0: done 1 cycle after accept, busy never 1, div_zero=1, Q=0xFFFFFFFF, R=5.
- Signed (DIV_SIGNED_EN), 0xFFFFFFF9 / 2 (−7/2): done at 34 cycles, Q=0xFFFFFFFD, R=0xFFFFFFFF.
  - Same build, 0x80000000 / 0xFFFFFFFF: Q=0x80000000, R=0.
- clear_n pulsed low 10 cycles into RUN: outputs go to 0 immediately, no done.
  - After release, 9 / 4 gives Q=2, R=1 at 33 cycles.
- start asserted every cycle during RUN with other operands: ignored, first result intact.
  - abort at cycle 5 with simultaneous start: IDLE, no done, previous results held.

Source files
------------

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential divider.
// Consumed by div_step and div_seq_ctrl.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract step of the divider.
// Purely combinational; the controller registers its outputs.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic             qmsb,
    input  logic [WIDTH-1:0] v,
    output logic [WIDTH-1:0] p_next,
    output logic             qbit
);

    logic [WIDTH:0] pp;

    // Shift in the next dividend bit, subtract if the divisor fits.
    // P < V always holds, so P'-V fits in WIDTH bits.
    always_comb begin
        pp     = {p, qmsb};
        qbit   = (pp >= {1'b0, v});
        p_next = qbit ? (pp[WIDTH-1:0] - v) : pp[WIDTH-1:0];
    end

endmodule

// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider sequencer (start/busy/done, abort).
// Optional signed support enabled by defining DIV_SIGNED_EN.
module div_seq_ctrl
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] qw_q;
    logic [WIDTH-1:0] v_q;
    logic [WIDTH-1:0] p_nx;
    logic             qbit;

    logic             accept;
    logic             vzero;
    logic             last;
    logic             fix_go;
    logic [WIDTH-1:0] mag_d;
    logic [WIDTH-1:0] mag_v;

`ifdef DIV_SIGNED_EN
    logic             sgn_q;
    logic             neg_q_q;
    logic             neg_r_q;
    logic             sgn_in;

    assign sgn_in = is_signed;
    assign mag_d  = (sgn_in && dividend[WIDTH-1]) ? -dividend : dividend;
    assign mag_v  = (sgn_in && divisor[WIDTH-1])  ? -divisor  : divisor;
    assign fix_go = sgn_q;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign mag_d  = dividend;
    assign mag_v  = divisor;
    assign fix_go = 1'b0;
`endif

    assign accept = (state_q == IDLE || state_q == DONE)
                  && start && !abort;
    assign vzero  = (divisor == '0);
    assign last   = (cnt_q == '0);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p_q),
        .qmsb   (qw_q[WIDTH-1]),
        .v      (v_q),
        .p_next (p_nx),
        .qbit   (qbit)
    );

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = vzero ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (abort) begin
                    state_d = IDLE;
                end else if (last) begin
                    state_d = fix_go ? FIX : DONE;
                end
            end
`ifdef DIV_SIGNED_EN
            FIX: begin
                busy    = 1'b1;
                state_d = abort ? IDLE : DONE;
            end
`endif
            DONE: begin
                done = 1'b1;
                if (accept) begin
                    state_d = vzero ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, shift-subtract datapath and result registers.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            cnt_q     <= '0;
            p_q       <= '0;
            qw_q      <= '0;
            v_q       <= '0;
            div_zero  <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (accept) begin
            cnt_q    <= CW'(WIDTH - 1);
            p_q      <= '0;
            qw_q     <= mag_d;
            v_q      <= mag_v;
            div_zero <= vzero;
            if (vzero) begin
                quotient  <= '1;
                remainder <= dividend;
            end
        end else if (state_q == RUN && !abort) begin
            p_q   <= p_nx;
            qw_q  <= {qw_q[WIDTH-2:0], qbit};
            cnt_q <= cnt_q - 1'b1;
            if (last && !fix_go) begin
                quotient  <= {qw_q[WIDTH-2:0], qbit};
                remainder <= p_nx;
            end
        end
`ifdef DIV_SIGNED_EN
        else if (state_q == FIX && !abort) begin
            quotient  <= neg_q_q ? -qw_q : qw_q;
            remainder <= neg_r_q ? -p_q : p_q;
        end
`endif
    end

`ifdef DIV_SIGNED_EN
    // Sign bookkeeping for the fix-up step.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            sgn_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            sgn_q   <= sgn_in;
            neg_q_q <= sgn_in
                     & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r_q <= sgn_in & dividend[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Scoreboard bench for div_seq_ctrl.
// Signed cases run only when DIV_SIGNED_EN is defined.
module tb_div_seq_ctrl;

    logic        clock;
    logic        clear_n;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        abort;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
        int          t;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   busy_seen;

    div_seq_ctrl u_dut (
        .clock     (clock),
        .clear_n   (clear_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Monitor: pop and compare every time done is presented.
    always @(negedge clock) begin
        if (clear_n && busy) busy_seen = 1'b1;
        if (clear_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got q=%h r=%h expected none",
                         quotient, remainder);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
                chk("latency", cyc - e.t, e.lat);
            end
        end
    end

    task automatic do_start(input logic [31:0] d, input logic [31:0] v,
                            input logic s, input logic [31:0] eq,
                            input logic [31:0] er, input logic ez,
                            input int lat, input bit exp_done);
        exp_t e;
        dividend  = d;
        divisor   = v;
        is_signed = s;
        start     = 1'b1;
        if (exp_done) begin
            e.q   = eq;
            e.r   = er;
            e.z   = ez;
            e.lat = lat;
            e.t   = cyc;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: got no done expected done within %0d",
                     max);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        cyc       = 0;
        n_cmp     = 0;
        n_bad     = 0;
        busy_seen = 1'b0;
        clear_n   = 1'b0;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        abort     = 1'b0;

        step(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        clear_n = 1'b1;
        step(2);

        // 100 / 7
        do_start(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 33, 1'b1);
        wait_done(40);
        step(2);

        // back-to-back, second start in the done cycle
        do_start(32'hFFFF_FFFF, 32'd1, 1'b0,
                 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b1);
        wait_done(40);
        do_start(32'd10, 32'd3, 1'b0, 32'd3, 32'd1, 1'b0, 33, 1'b1);
        wait_done(40);
        step(2);

        // divide by zero
        busy_seen = 1'b0;
        do_start(32'd5, 32'd0, 1'b0,
                 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b1);
        wait_done(3);
        step(2);
        chk("dz_busy_seen", {31'd0, busy_seen}, 32'd0);

`ifdef DIV_SIGNED_EN
        do_start(32'hFFFF_FFF9, 32'd2, 1'b1,
                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, 1'b1);
        wait_done(40);
        step(2);
        do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
                 32'h8000_0000, 32'd0, 1'b0, 34, 1'b1);
        wait_done(40);
        step(2);
`endif

        // reset during run
        do_start(32'd123456, 32'd7, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        step(9);
        clear_n = 1'b0;
        #1;
        chk("mid_rst_q", quotient, 32'd0);
        chk("mid_rst_r", remainder, 32'd0);
        chk("mid_rst_dz", {31'd0, div_zero}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        step(2);
        clear_n = 1'b1;
        step(3);
        do_start(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, 33, 1'b1);
        wait_done(40);
        step(2);

        // start held during run is ignored
        do_start(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 33, 1'b1);
        for (int i = 0; i < 40 && !done; i++) begin
            start    = busy;
            dividend = 32'h1234 + i;
            divisor  = 32'd3;
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        wait_done(1);
        step(2);

        // abort with simultaneous start
        do_start(32'd50, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0, 1'b0);
        step(4);
        abort    = 1'b1;
        start    = 1'b1;
        dividend = 32'd8;
        divisor  = 32'd2;
        step(1);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_q", quotient, 32'd100);
        chk("abort_r", remainder, 32'd0);
        chk("abort_dz", {31'd0, div_zero}, 32'd0);
        step(40);
        chk("abort_idle", {31'd0, busy}, 32'd0);

        chk("pending", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
